// File: rtl/conv_cfg_pkg.sv
// Shared types and constants for the conv filter coefficient sequencer.
package conv_cfg_pkg;

  localparam int N      = 25;  // kernel taps, 5x5 row-major
  localparam int BW     = 8;   // signed coefficient width
  localparam int CENTRE = 12;  // centre tap index

  // h[i] is the BW-bit signed coefficient of tap i
  typedef logic signed [0:N-1][BW-1:0] kernel_t;

  typedef struct packed {
    kernel_t     h;
    logic [15:0] scale;
  } cfg_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    ARMED = 2'd2
  } state_t;

  localparam logic [1:0] PRESET_IDENTITY = 2'd0;
  localparam logic [1:0] PRESET_BOX      = 2'd1;
  localparam logic [1:0] PRESET_GAUSS    = 2'd2;
  localparam logic [1:0] PRESET_LAPLACE  = 2'd3;

  // Pass-through kernel: centre tap 1, divisor 1
  function automatic cfg_t identity_cfg();
    cfg_t c;
    c          = '0;
    c.h[CENTRE] = BW'(1);
    c.scale    = 16'd1;
    return c;
  endfunction

endpackage

// File: rtl/conv_kernel_rom.sv
// Preset kernel table: (sel, tap index) -> coefficient, sel -> divisor.
module conv_kernel_rom
  import conv_cfg_pkg::*;
(
  input  logic [1:0]    sel,
  input  logic [4:0]    idx,
  output logic [BW-1:0] coeff,
  output logic [15:0]   scale
);

  logic          in_box_s;
  logic [BW-1:0] gauss_s;

  // Flag taps inside the 3x3 window centred in the 5x5 grid
  always_comb begin
    case (idx)
      5'd6, 5'd7, 5'd8, 5'd11, 5'd12, 5'd13, 5'd16, 5'd17, 5'd18: in_box_s = 1'b1;
      default: in_box_s = 1'b0;
    endcase
  end

  // Gaussian taps, grouped by their symmetric position class
  always_comb begin
    case (idx)
      5'd0, 5'd4, 5'd20, 5'd24:                          gauss_s = 8'd1;
      5'd1, 5'd3, 5'd5, 5'd9, 5'd15, 5'd19, 5'd21, 5'd23: gauss_s = 8'd4;
      5'd2, 5'd10, 5'd14, 5'd22:                         gauss_s = 8'd7;
      5'd6, 5'd8, 5'd16, 5'd18:                          gauss_s = 8'd20;
      5'd7, 5'd11, 5'd13, 5'd17:                         gauss_s = 8'd33;
      5'd12:                                             gauss_s = 8'd55;
      default:                                           gauss_s = 8'd0;
    endcase
  end

  // Coefficient select per preset
  always_comb begin
    coeff = 8'd0;
    case (sel)
      PRESET_IDENTITY: coeff = (idx == 5'd12) ? 8'd1 : 8'd0;
      PRESET_BOX:      coeff = in_box_s ? 8'd1 : 8'd0;
      PRESET_GAUSS:    coeff = gauss_s;
      PRESET_LAPLACE:  coeff = (idx == 5'd12) ? 8'd8 : (in_box_s ? 8'hFF : 8'd0);
      default:         coeff = 8'd0;
    endcase
  end

  // Divisor per preset; never zero
  always_comb begin
    scale = 16'd1;
    case (sel)
      PRESET_IDENTITY: scale = 16'd1;
      PRESET_BOX:      scale = 16'd9;
      PRESET_GAUSS:    scale = 16'd331;
      PRESET_LAPLACE:  scale = 16'd1;
      default:         scale = 16'd1;
    endcase
  end

endmodule

// File: rtl/conv_kernel_sequencer.sv
// Coefficient owner for the 5x5 conv filter: shadow bank loaded from a preset
// or the host, swapped into the active bank only on the last pixel of a frame.
module conv_kernel_sequencer
  import conv_cfg_pkg::*;
#(
  parameter int WIDTH  = 320,
  parameter int HEIGHT = 240
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [1:0]           sel,
  input  logic                 sel_stb,
  input  logic                 wr_en,
  input  logic [4:0]           wr_addr,
  input  logic signed [BW-1:0] wr_data,
  input  logic                 wr_scale,
  input  logic                 commit,
  input  logic                 pix_valid,
  input  logic                 pix_ready,
  input  logic                 frame_sync,
  output kernel_t              h,
  output logic [15:0]          scale_down,
  output logic                 busy,
  output logic                 swap_pulse,
  output logic                 wr_err
);

  localparam int            FRAME_PIX = WIDTH * HEIGHT;
  localparam int            CW        = $clog2(FRAME_PIX);
  localparam logic [CW-1:0] LAST_PIX  = CW'(FRAME_PIX - 1);

  state_t        state_r, state_nxt_s;
  logic [4:0]    ld_idx_r;
  logic [1:0]    sel_r;
  cfg_t          shadow_r, active_r;
  logic [CW-1:0] pix_cnt_r;
  logic          busy_r, swap_d_r, swap_pulse_r, wr_err_r;

  logic          hs_s, frame_last_s;
  logic          ld_start_s, ld_tap_s, ld_last_s, swap_s, host_wr_s, err_set_s, err_clr_s;
  logic [BW-1:0] rom_coeff_s;
  logic [15:0]   rom_scale_s;

  assign hs_s         = pix_valid & pix_ready;
  assign frame_last_s = hs_s & (pix_cnt_r == LAST_PIX);

  conv_kernel_rom u_rom (
    .sel   (sel_r),
    .idx   (ld_idx_r),
    .coeff (rom_coeff_s),
    .scale (rom_scale_s)
  );

  // FSM state register; busy registered from the next state
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s != IDLE);
    end
  end

  // FSM next-state logic; sel_stb has priority in every state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE:    state_nxt_s = sel_stb ? LOAD : (commit ? ARMED : IDLE);
      LOAD:    state_nxt_s = sel_stb ? LOAD : ((ld_idx_r == 5'(N - 1)) ? ARMED : LOAD);
      ARMED:   state_nxt_s = sel_stb ? LOAD : (frame_last_s ? IDLE : ARMED);
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM output strobes driving the datapath registers
  always_comb begin
    ld_start_s = sel_stb;
    ld_tap_s   = 1'b0;
    swap_s     = 1'b0;
    host_wr_s  = 1'b0;
    err_set_s  = 1'b0;
    err_clr_s  = 1'b0;
    case (state_r)
      IDLE: begin
        host_wr_s = wr_en;
        err_clr_s = sel_stb | commit;
      end
      LOAD: begin
        ld_tap_s  = ~sel_stb;
        err_set_s = wr_en;
      end
      ARMED: begin
        swap_s    = ~sel_stb & frame_last_s;
        err_set_s = wr_en;
      end
      default: begin
        ld_start_s = 1'b0;
      end
    endcase
  end

  assign ld_last_s = ld_tap_s & (ld_idx_r == 5'(N - 1));

  // Preset latch and load tap index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_r    <= PRESET_IDENTITY;
      ld_idx_r <= 5'd0;
    end else if (ld_start_s) begin
      sel_r    <= sel;
      ld_idx_r <= 5'd0;
    end else if (ld_tap_s) begin
      ld_idx_r <= ld_idx_r + 5'd1;
    end
  end

  // Shadow bank: one ROM tap per LOAD cycle, or a single host write in IDLE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow_r <= identity_cfg();
    end else if (ld_tap_s) begin
      shadow_r.h[ld_idx_r] <= rom_coeff_s;
      if (ld_last_s) shadow_r.scale <= rom_scale_s;
    end else if (host_wr_s) begin
      if (wr_scale) shadow_r.scale <= (wr_data == 8'sd0) ? 16'd1 : {8'd0, wr_data};
      else if (wr_addr < 5'(N)) shadow_r.h[wr_addr] <= wr_data;
    end
  end

  // Active bank and the delayed swap notification
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_r     <= identity_cfg();
      swap_d_r     <= 1'b0;
      swap_pulse_r <= 1'b0;
    end else begin
      if (swap_s) active_r <= shadow_r;
      swap_d_r     <= swap_s;
      swap_pulse_r <= swap_d_r;
    end
  end

  // Pixel position within the frame, resynchronised by frame_sync
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_cnt_r <= '0;
    end else if (frame_sync) begin
      pix_cnt_r <= hs_s ? CW'(1) : CW'(0);
    end else if (hs_s) begin
      pix_cnt_r <= (pix_cnt_r == LAST_PIX) ? CW'(0) : pix_cnt_r + CW'(1);
    end
  end

  // Sticky host-write error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_err_r <= 1'b0;
    end else if (err_set_s) begin
      wr_err_r <= 1'b1;
    end else if (err_clr_s) begin
      wr_err_r <= 1'b0;
    end
  end

  assign h          = active_r.h;
  assign scale_down = active_r.scale;
  assign busy       = busy_r;
  assign swap_pulse = swap_pulse_r;
  assign wr_err     = wr_err_r;

endmodule

// File: tb/tb_conv_kernel_sequencer.sv
// Scoreboard bench for conv_kernel_sequencer on a reduced 16x8 frame.
module tb_conv_kernel_sequencer;
  import conv_cfg_pkg::*;

  localparam int W  = 16;
  localparam int H  = 8;
  localparam int FP = W * H;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  sel = 2'd0;
  logic        sel_stb = 1'b0, wr_en = 1'b0, wr_scale = 1'b0, commit = 1'b0;
  logic [4:0]  wr_addr = 5'd0;
  logic signed [7:0] wr_data = 8'sd0;
  logic        pix_valid = 1'b0, pix_ready = 1'b0, frame_sync = 1'b0;
  kernel_t     h;
  logic [15:0] scale_down;
  logic        busy, swap_pulse, wr_err;

  conv_kernel_sequencer #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk(clk), .rst_n(rst_n), .sel(sel), .sel_stb(sel_stb), .wr_en(wr_en),
    .wr_addr(wr_addr), .wr_data(wr_data), .wr_scale(wr_scale), .commit(commit),
    .pix_valid(pix_valid), .pix_ready(pix_ready), .frame_sync(frame_sync),
    .h(h), .scale_down(scale_down), .busy(busy), .swap_pulse(swap_pulse), .wr_err(wr_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    kernel_t     kh;
    logic [15:0] sc;
    int          cyc;
  } swap_t;

  swap_t sb_q[$];
  swap_t mon_e;
  int    total = 0;
  int    bad   = 0;
  int    cyc   = 0;
  int    pops  = 0;

  byte unsigned gauss_tab [25] = '{1,4,7,4,1, 4,20,33,20,4, 7,33,55,33,7, 4,20,33,20,4, 1,4,7,4,1};

  // reference model state
  int          m_state, m_idx, m_cnt;
  logic [1:0]  m_sel;
  logic        m_err;
  kernel_t     m_sh, m_act, ident_k;
  logic [15:0] m_sh_sc, m_act_sc;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_tap(input logic [1:0] s, input int i);
    int rr, cc;
    bit inner;
    rr = i / 5;
    cc = i % 5;
    inner = (rr >= 1 && rr <= 3 && cc >= 1 && cc <= 3);
    case (s)
      2'd0:    return (i == 12) ? 8'd1 : 8'd0;
      2'd1:    return inner ? 8'd1 : 8'd0;
      2'd2:    return gauss_tab[i];
      default: return (i == 12) ? 8'd8 : (inner ? 8'hFF : 8'd0);
    endcase
  endfunction

  function automatic logic [15:0] ref_scale(input logic [1:0] s);
    case (s)
      2'd1:    return 16'd9;
      2'd2:    return 16'd331;
      default: return 16'd1;
    endcase
  endfunction

  task automatic model_reset();
    m_state = 0; m_idx = 0; m_cnt = 0; m_sel = 2'd0; m_err = 1'b0;
    m_sh = ident_k; m_act = ident_k; m_sh_sc = 16'd1; m_act_sc = 16'd1;
  endtask

  // one clock: drive handshake, advance model across the edge, check, drop pulses
  task automatic step(input logic v, input logic r);
    logic hs, fl, do_swap;
    pix_valid = v;
    pix_ready = r;
    hs = v & r;
    fl = hs && (m_cnt == FP - 1);
    do_swap = 1'b0;
    @(posedge clk);
    if (frame_sync) m_cnt = hs ? 1 : 0;
    else if (hs) m_cnt = (m_cnt == FP - 1) ? 0 : m_cnt + 1;
    if (wr_en && m_state != 0) m_err = 1'b1;
    case (m_state)
      0: begin
        if (wr_en) begin
          if (wr_scale) m_sh_sc = (wr_data == 8'sd0) ? 16'd1 : {8'd0, wr_data};
          else if (wr_addr < 5'd25) m_sh[wr_addr] = wr_data;
        end
        if (sel_stb) begin m_sel = sel; m_idx = 0; m_state = 1; m_err = 1'b0; end
        else if (commit) begin m_state = 2; m_err = 1'b0; end
      end
      1: begin
        if (sel_stb) begin m_sel = sel; m_idx = 0; end
        else begin
          m_sh[m_idx] = ref_tap(m_sel, m_idx);
          if (m_idx == 24) begin m_sh_sc = ref_scale(m_sel); m_state = 2; end
          else m_idx++;
        end
      end
      default: begin
        if (sel_stb) begin m_sel = sel; m_idx = 0; m_state = 1; end
        else if (fl) begin m_act = m_sh; m_act_sc = m_sh_sc; m_state = 0; do_swap = 1'b1; end
      end
    endcase
    #1;
    if (do_swap) sb_q.push_back('{m_act, m_act_sc, cyc});
    check_val("busy", busy, m_state != 0);
    check_val("wr_err", wr_err, m_err);
    check_val("h_hold", h, m_act);
    check_val("scale_hold", scale_down, m_act_sc);
    sel_stb = 1'b0; commit = 1'b0; wr_en = 1'b0; wr_scale = 1'b0; frame_sync = 1'b0;
  endtask

  // run until exactly n handshakes, with random valid/ready gaps
  task automatic run_hs(input int n);
    int got, budget;
    logic v, r;
    got = 0;
    budget = n * 8 + 64;
    while (got < n && budget > 0) begin
      v = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 3) != 0);
      if (v & r) got++;
      step(v, r);
      budget--;
    end
    check_val("run_hs_budget", got, n);
  endtask

  // cycle counter used to time swap_pulse against the swap edge
  always @(posedge clk) cyc <= cyc + 1;

  // scoreboard consumer: each swap_pulse must match a pushed swap one cycle later
  always @(negedge clk) begin
    if (rst_n && swap_pulse) begin
      if (sb_q.size() == 0) begin
        check_val("swap_unexpected", swap_pulse, 1'b0);
      end else begin
        mon_e = sb_q.pop_front();
        pops++;
        check_val("sb_h", h, mon_e.kh);
        check_val("sb_scale", scale_down, mon_e.sc);
        check_val("sb_pulse_cyc", cyc, mon_e.cyc + 1);
      end
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    ident_k = '0;
    ident_k[12] = 8'd1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_h", h, ident_k);
    check_val("rst_scale", scale_down, 16'd1);
    check_val("rst_busy", busy, 1'b0);
    check_val("rst_swap", swap_pulse, 1'b0);
    check_val("rst_wr_err", wr_err, 1'b0);
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // T1: a full frame with nothing armed leaves identity, no swap
    run_hs(FP);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("t1_pops", pops, 0);
    check_val("t1_h", h, ident_k);

    // T2: Gaussian preset requested mid-frame, swapped on the frame's last pixel
    run_hs(100);
    sel = 2'd2; sel_stb = 1'b1; step(1'b0, 1'b0);
    check_val("t2_busy", busy, 1'b1);
    run_hs(FP - 100);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("t2_pops", pops, 1);
    check_val("t2_h12", h[12], 8'd55);
    check_val("t2_h0", h[0], 8'd1);
    check_val("t2_scale", scale_down, 16'd331);
    check_val("t2_busy_end", busy, 1'b0);

    // T3: LOAD restarted at tap 10 with the Laplacian preset
    sel = 2'd2; sel_stb = 1'b1; step(1'b0, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    sel = 2'd3; sel_stb = 1'b1; step(1'b0, 1'b0);
    run_hs(FP - 10);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("t3_pops", pops, 2);
    check_val("t3_h12", h[12], 8'd8);
    check_val("t3_h6", h[6], 8'hFF);
    check_val("t3_h0", h[0], 8'd0);
    check_val("t3_h2", h[2], 8'd0);
    check_val("t3_scale", scale_down, 16'd1);

    // T4: host writes, zero scale stored as 1, write while ARMED rejected
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = -8'sd2; step(1'b0, 1'b0);
    wr_en = 1'b1; wr_scale = 1'b1; wr_data = 8'sd0; step(1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd30; wr_data = 8'sd9; step(1'b0, 1'b0);
    commit = 1'b1; step(1'b0, 1'b0);
    wr_en = 1'b1; wr_addr = 5'd1; wr_data = 8'sd5; step(1'b0, 1'b0);
    check_val("t4_wr_err", wr_err, 1'b1);
    run_hs(FP);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("t4_pops", pops, 3);
    check_val("t4_h0", h[0], 8'hFE);
    check_val("t4_h1", h[1], 8'd0);
    check_val("t4_h12", h[12], 8'd8);
    check_val("t4_scale", scale_down, 16'd1);

    // T5: frame_sync alone, then frame_sync with a handshake, moves the swap point
    wr_en = 1'b1; wr_addr = 5'd12; wr_data = 8'sd3; step(1'b0, 1'b0);
    wr_en = 1'b1; wr_scale = 1'b1; wr_data = 8'sd200; step(1'b0, 1'b0);
    commit = 1'b1; step(1'b0, 1'b0);
    check_val("t5_wr_err_clr", wr_err, 1'b0);
    run_hs(20);
    frame_sync = 1'b1; step(1'b0, 1'b0);
    run_hs(50);
    frame_sync = 1'b1; step(1'b1, 1'b1);
    run_hs(FP - 2);
    check_val("t5_no_early_h12", h[12], 8'd8);
    check_val("t5_no_early_pops", pops, 3);
    run_hs(1);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("t5_pops", pops, 4);
    check_val("t5_h12", h[12], 8'd3);
    check_val("t5_scale", scale_down, 16'd200);

    // T6: reset while ARMED discards the pending box kernel
    sel = 2'd1; sel_stb = 1'b1; step(1'b0, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    check_val("t6_armed_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check_val("t6_rst_h", h, ident_k);
    check_val("t6_rst_scale", scale_down, 16'd1);
    check_val("t6_rst_busy", busy, 1'b0);
    model_reset();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;
    run_hs(FP + 5);
    step(1'b0, 1'b0); step(1'b0, 1'b0);
    check_val("t6_pops", pops, 4);
    check_val("t6_h", h, ident_k);
    check_val("sb_empty", sb_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
